// File: rtl/icache_refill.sv
// I-cache line refill engine: fetches a 4-word line critical-word-first and writes
// each beat into the data array as a byte-masked partial write.
`default_nettype none

module icache_refill #(
  parameter int SET_BITS   = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    miss_req,
  input  logic [31:0]             miss_addr,
  output logic                    refill_busy,
  output logic                    refill_done,
  output logic                    crit_valid,
  output logic [31:0]             crit_data,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [31:0]             mem_rdata,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic [4*LINE_WORDS-1:0] sram_wmask,
  output logic [SET_BITS-1:0]     sram_addr,
  output logic [32*LINE_WORDS-1:0] sram_din
);

  localparam int WIDX = $clog2(LINE_WORDS);
  localparam logic [WIDX-1:0] LAST_BEAT = WIDX'(LINE_WORDS - 1);
  localparam logic [4*LINE_WORDS-1:0] WORD_MASK = {{(4*LINE_WORDS-4){1'b0}}, 4'hF};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FILL  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state_q;
  logic [WIDX-1:0]          start_q;
  logic [WIDX-1:0]          cnt_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     crit_valid_q;
  logic [31:0]              crit_data_q;
  logic                     mem_req_q;
  logic [31:0]              mem_addr_q;
  logic                     csb_q;
  logic                     web_q;
  logic [4*LINE_WORDS-1:0]  wmask_q;
  logic [SET_BITS-1:0]      sram_addr_q;
  logic [32*LINE_WORDS-1:0] din_q;

  logic [WIDX-1:0] word_idx;
  logic            addr_lsb_unused;

  // Wrap order: the beat counter is offset by the critical word index modulo the line size.
  assign word_idx        = start_q + cnt_q;
  assign addr_lsb_unused = ^miss_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_q      <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      wmask_q      <= '0;
      sram_addr_q  <= '0;
      din_q        <= '0;
    end else begin
      done_q       <= 1'b0;
      crit_valid_q <= 1'b0;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      wmask_q      <= '0;
      din_q        <= '0;
      case (state_q)
        S_IDLE: begin
          if (miss_req) begin
            state_q     <= S_REQ;
            busy_q      <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= {miss_addr[31:2], 2'b00};
            sram_addr_q <= miss_addr[SET_BITS+3:4];
            start_q     <= miss_addr[WIDX+1:2];
            cnt_q       <= '0;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            state_q   <= S_FILL;
            mem_req_q <= 1'b0;
          end
        end
        S_FILL: begin
          if (mem_rvalid) begin
            csb_q   <= 1'b0;
            web_q   <= 1'b0;
            wmask_q <= WORD_MASK << {word_idx, 2'b00};
            din_q   <= {{(32*LINE_WORDS-32){1'b0}}, mem_rdata} << {word_idx, 5'b00000};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == '0) begin
              crit_valid_q <= 1'b1;
              crit_data_q  <= mem_rdata;
            end
            if (cnt_q == LAST_BEAT) begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // Dummy read in DONE flushes the array's registered write enable.
          state_q <= S_DONE;
          csb_q   <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign refill_busy = busy_q;
  assign refill_done = done_q;
  assign crit_valid  = crit_valid_q;
  assign crit_data   = crit_data_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign sram_csb    = csb_q;
  assign sram_web    = web_q;
  assign sram_wmask  = wmask_q;
  assign sram_addr   = sram_addr_q;
  assign sram_din    = din_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_refill.sv
// Randomized self-checking bench for icache_refill with a transaction-level model and SRAM array model.
`timescale 1ns/1ps
module tb_icache_refill;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         refill_busy, refill_done, crit_valid, mem_req, sram_csb, sram_web;
  logic [31:0]  crit_data, mem_addr;
  logic [15:0]  sram_wmask;
  logic [5:0]   sram_addr;
  logic [127:0] sram_din;

  icache_refill #(.SET_BITS(6), .LINE_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
    .refill_busy(refill_busy), .refill_done(refill_done),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level expectation: refill phase plus outputs derived from the refill rules.
  int           ph;      // 0 idle, 1 request, 2 filling, 3 flush, 4 done
  int           nbeats;
  int           st;
  logic         e_busy, e_done, e_cv, e_mreq, e_csb, e_web;
  logic [31:0]  e_cd, e_maddr;
  logic [15:0]  e_wm;
  logic [5:0]   e_sa;
  logic [127:0] e_din;

  task automatic model_step();
    int w;
    if (!rst_n) begin
      ph = 0; nbeats = 0; st = 0;
      e_busy = 0; e_done = 0; e_cv = 0; e_cd = 0; e_mreq = 0; e_maddr = 0;
      e_csb = 1; e_web = 1; e_wm = 0; e_sa = 0; e_din = 0;
    end else begin
      e_done = 0; e_cv = 0; e_csb = 1; e_web = 1; e_wm = 0; e_din = 0;
      case (ph)
        0: if (miss_req) begin
          ph = 1; e_maddr = {miss_addr[31:2], 2'b00}; e_sa = miss_addr[9:4];
          st = int'(miss_addr[3:2]); nbeats = 0;
        end
        1: if (mem_gnt) ph = 2;
        2: if (mem_rvalid) begin
          w = (st + nbeats) % 4;
          e_csb = 0; e_web = 0;
          e_wm  = 16'hF << (4 * w);
          e_din = 128'(mem_rdata) << (32 * w);
          if (nbeats == 0) begin e_cv = 1; e_cd = mem_rdata; end
          nbeats++;
          if (nbeats == 4) ph = 3;
        end
        3: begin ph = 4; e_csb = 0; e_done = 1; end
        default: ph = 0;
      endcase
      e_busy = (ph != 0);
      e_mreq = (ph == 1);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Data-array model driven by the DUT's SRAM port.
  logic [127:0] arr [64];
  initial forever begin
    @(posedge clk);
    if (rst_n && !sram_csb && !sram_web)
      for (int b = 0; b < 16; b++)
        if (sram_wmask[b]) arr[sram_addr][8*b +: 8] = sram_din[8*b +: 8];
  end

  int          done_cnt = 0;
  logic [31:0] last_crit = '0;
  logic [31:0] last_maddr = '0;
  logic [15:0] wq [$];
  logic [5:0]  aq [$];

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy", refill_busy, e_busy);
      chk("done", refill_done, e_done);
      chk("crit_valid", crit_valid, e_cv);
      chk("crit_data", crit_data, e_cd);
      chk("mem_req", mem_req, e_mreq);
      chk("mem_addr", mem_addr, e_maddr);
      chk("sram_csb", sram_csb, e_csb);
      chk("sram_web", sram_web, e_web);
      chk("sram_wmask", sram_wmask, e_wm);
      chk("sram_addr", sram_addr, e_sa);
      chk("sram_din", sram_din, e_din);
      if (refill_done) done_cnt++;
      if (crit_valid) last_crit = crit_data;
      if (mem_req) last_maddr = mem_addr;
      if (!sram_csb && !sram_web) begin wq.push_back(sram_wmask); aq.push_back(sram_addr); end
    end
  end

  logic [31:0] d [4];

  task automatic refill(input logic [31:0] a, input int gdly, input int gapmax,
                        input bit intf, input bit abort);
    int s, t, done0;
    s = int'(a[3:2]);
    done0 = done_cnt;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    wq.delete(); aq.delete();
    miss_req = 1'b1; miss_addr = a;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (!refill_busy && t < 10);
    chk("accept", refill_busy, 1'b1);
    miss_req = 1'b0;
    for (int k = 0; k < gdly; k++) begin
      mem_gnt = 1'b0;
      mem_rvalid = intf ? 1'($urandom_range(0, 1)) : 1'b0;
      miss_req   = intf ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata  = $urandom;
      @(negedge clk); #1;
    end
    mem_gnt = 1'b1; mem_rvalid = intf; mem_rdata = $urandom;
    @(negedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("no_write_before_fill", 32'(wq.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, gapmax)) begin
        miss_req = intf ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk); #1;
      end
      miss_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = d[(s + i) % 4];
      @(negedge clk); #1;
      mem_rvalid = 1'b0;
      if (abort && i == 1) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", refill_busy, 1'b0);   chk("rst_done", refill_done, 1'b0);
        chk("rst_cv", crit_valid, 1'b0);      chk("rst_cd", crit_data, 32'd0);
        chk("rst_mreq", mem_req, 1'b0);       chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_csb", sram_csb, 1'b1);       chk("rst_web", sram_web, 1'b1);
        chk("rst_wmask", sram_wmask, 16'd0);  chk("rst_saddr", sram_addr, 6'd0);
        chk("rst_din", sram_din, 128'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (6) begin @(negedge clk); #1; end
        chk("abort_no_done", 32'(done_cnt - done0), 32'd0);
        return;
      end
    end
    t = 0;
    while (!refill_done && t < 10) begin @(negedge clk); #1; t++; end
    chk("done_seen", refill_done, 1'b1);
    @(negedge clk); #1;
    chk("idle_after_done", refill_busy, 1'b0);
    chk("line_readback", arr[a[9:4]], {d[3], d[2], d[1], d[0]});
    chk("one_done_pulse", 32'(done_cnt - done0), 32'd1);
    chk("crit_word", last_crit, d[s]);
    chk("write_count", 32'(wq.size()), 32'd4);
    if (wq.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("write_order", wq[i], 16'hF << (4 * ((s + i) % 4)));
        chk("write_index", aq[i], a[9:4]);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) arr[i] = {$urandom, $urandom, $urandom, $urandom};
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_busy", refill_busy, 1'b0);
    chk("reset_csb", sram_csb, 1'b1);
    chk("reset_web", sram_web, 1'b1);
    chk("reset_wmask", sram_wmask, 16'd0);
    chk("reset_mreq", mem_req, 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // Basic miss, start word 0, line 0x14
    refill(32'h0000_0140, 0, 0, 1'b0, 1'b0);
    chk("basic_crit", last_crit, d[0]);
    if (wq.size() == 4) begin
      chk("basic_m0", wq[0], 16'h000F); chk("basic_m1", wq[1], 16'h00F0);
      chk("basic_m2", wq[2], 16'h0F00); chk("basic_m3", wq[3], 16'hF000);
      chk("basic_idx", aq[0], 6'h14);
    end
    chk("basic_line", arr[6'h14], {d[3], d[2], d[1], d[0]});

    // Critical-word wrap, start word 3, line 0x3F
    refill(32'h0000_03FC, 0, 0, 1'b0, 1'b0);
    chk("wrap_maddr", last_maddr, 32'h0000_03FC);
    chk("wrap_crit", last_crit, d[3]);
    if (wq.size() == 4) begin
      chk("wrap_m0", wq[0], 16'hF000); chk("wrap_m1", wq[1], 16'h000F);
      chk("wrap_m2", wq[2], 16'h00F0); chk("wrap_m3", wq[3], 16'h0F00);
      chk("wrap_idx", aq[0], 6'h3F);
    end

    refill($urandom, 5, 3, 1'b0, 1'b0);   // stalled memory
    refill($urandom, 3, 2, 1'b1, 1'b0);   // interference
    refill($urandom, 1, 1, 1'b0, 1'b1);   // reset mid-fill
    refill($urandom, 0, 1, 1'b0, 1'b0);   // recovery after reset
    for (int n = 0; n < 12; n++)
      refill($urandom, $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_refill.md
# icache_refill

Instruction-cache line refill engine that sits directly upstream of the `icache_data_array` SRAM write port. On an I-cache miss it requests a 16-byte line from the memory side, accepts four 32-bit beats in critical-word-first wrap order, and writes each beat into the data array as a byte-masked partial write. It forwards the critical word early to the fetch stage and pulses `refill_done` once the whole line is committed and readable.

## Interface
- `SET_BITS`, 6: line index width; matches data-array depth of 64.
- `LINE_WORDS`, 4: 32-bit words per line; fixed, 128-bit line.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `miss_req` in 1: miss request; sampled only in IDLE.
- `miss_addr` in 32: byte address of the missing fetch; latched when `miss_req` is accepted.
- `refill_busy` out 1: high from the cycle after acceptance through DONE; while high, this block owns the SRAM port.
- `refill_done` out 1: one-cycle pulse in DONE; the line is readable from the next cycle.
- `crit_valid` out 1: one-cycle pulse carrying the critical word.
- `crit_data` out 32: the first beat received.
- `mem_req` out 1: line read request, held until `mem_gnt`.
- `mem_addr` out 32: `{miss_addr[31:2], 2'b00}`, the critical-word address.
- `mem_gnt` in 1: request accepted.
- `mem_rvalid` in 1: beat valid.
- `mem_rdata` in 32: beat data.
- `sram_csb` out 1: active-low chip select.
- `sram_web` out 1: active-low write enable.
- `sram_wmask` out 16: byte write mask.
- `sram_addr` out 6: line index, `miss_addr[9:4]`.
- `sram_din` out 128: write data.

## Operation
- States: IDLE, REQ, FILL, FLUSH, DONE.
- **IDLE**
  - On `miss_req`, latch `miss_addr`.
  - Set `start = miss_addr[3:2]`, clear the beat counter, go to REQ.
- **REQ**
  - Drive `mem_req`=1 and `mem_addr`.
  - On `mem_gnt`, go to FILL; `mem_req` is low the next cycle.
  - `mem_rvalid` is ignored in REQ.
- **FILL**
  - Each edge with `mem_rvalid`=1 accepts one beat.
  - The beat's word index is `w = (start + cnt) mod 4`; `cnt` increments by 1.
  - Gaps between beats are allowed.
  - On the 4th beat, go to FLUSH.
- **SRAM write stage (registered)**
  - A beat accepted at edge k drives, during cycle k+1:
    - `sram_csb`=0, `sram_web`=0
    - `sram_wmask` = `4'hF << 4w`
    - `sram_din[32w+31:32w]` = beat; all other bits 0.
  - In every other cycle of IDLE, REQ and FILL: `sram_csb`=1, `sram_web`=1, `sram_wmask`=0, `sram_din`=0.
- **FLUSH**: presents the 4th beat's write.
- **DONE**
  - Drive `sram_csb`=0, `sram_web`=1 (dummy read of the line index). This clears the data array's registered write enable, so the final write is not re-applied with stale state.
  - Assert `refill_done`, then go to IDLE.
- **Critical word**: `crit_valid`=1 and `crit_data` = first beat, in the cycle after the first beat is accepted.
- **Ownership**: while `refill_busy`=1, the external SRAM port mux selects this block.
- **Tag valid**: the tag array sets valid only on `refill_done`.

## Timing
- Reset values (asynchronous): state=IDLE, cnt=0, `refill_busy`=0, `refill_done`=0, `crit_valid`=0, `crit_data`=0, `mem_req`=0, `mem_addr`=0, `sram_csb`=1, `sram_web`=1, `sram_wmask`=0, `sram_addr`=0, `sram_din`=0.
- Nominal timeline (`miss_req` at cycle 0, `mem_gnt` at cycle 1, back-to-back beats at cycles 2–5):
  - `mem_req` in cycle 1.
  - SRAM writes in cycles 3–6 (FLUSH = cycle 6).
  - `crit_valid` in cycle 3.
  - DONE in cycle 7.
  - IDLE and `refill_busy`=0 in cycle 8.
- If `mem_gnt` is high in the first REQ cycle, the request is accepted with no extra wait.
- `miss_req` while busy is ignored. The requester must hold it until `refill_busy` is seen.
- `mem_rvalid` outside FILL is ignored.
- Wrap-around: start=3 gives word order 3, 0, 1, 2.
- Reset mid-refill returns immediately to the reset values above. The partial line is left in the SRAM but is never marked valid.

## Test plan
- **Basic miss**: `miss_addr`=0x0000_0140 (start 0), beats A0..A3 back-to-back.
  - Expect wmasks 0x000F, 0x00F0, 0x0F00, 0xF000 at `sram_addr`=0x14.
  - Expect `crit_data`=A0.
  - Readback of line 0x14 = {A3, A2, A1, A0}.
- **Critical word wrap**: `miss_addr`=0x0000_03FC (index 0x3F, start 3).
  - Expect `mem_addr`=0x0000_03FC.
  - Expect writes to words 3, 0, 1, 2 in that order and `crit_data` = first beat.
- **Stalled memory**: `mem_gnt` delayed 5 cycles, random 0–3 cycle gaps between beats.
  - Expect `mem_req` held throughout the delay.
  - Expect exactly 4 writes, correct line contents, and one `refill_done` pulse.
- **Interference**: `miss_req` pulses while busy, plus `mem_rvalid` asserted during REQ.
  - Expect no second request and no SRAM write before FILL.
- **Reset mid-fill**: `rst_n` low after beat 2.
  - Expect all outputs at reset values asynchronously and no `refill_done`.
  - A subsequent miss completes normally.
- **Read-after-refill**: read the line in the cycle after `refill_done`.
  - Expect the full new line with no stale word.
